// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD digit constants and helpers
package bcd_pkg;

   localparam int         BCD_W   = 4;
   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   // True when the nibble is a legal decimal digit (0..9)
   function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
      return (digit <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade with load, carry/borrow in and carry/borrow out
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [BCD_W-1:0] ld_digit,
   input  logic             ci,
   input  logic             up,
   input  logic             hold_en,
   output logic [BCD_W-1:0] q,
   output logic             co
);

   logic [BCD_W-1:0] r_q;

   // Digit register: reset, sanitised load, then step by one when carry/borrow arrives
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= BCD_MIN;
      end else if (load) begin
         r_q <= is_bcd(ld_digit) ? ld_digit : BCD_MIN;
      end else if (ci && !hold_en) begin
         if (up) begin
            r_q <= (r_q == BCD_MAX) ? BCD_MIN : r_q + 4'd1;
         end else begin
            r_q <= (r_q == BCD_MIN) ? BCD_MAX : r_q - 4'd1;
         end
      end
   end

   assign q  = r_q;
   assign co = ci & (up ? (r_q == BCD_MAX) : (r_q == BCD_MIN));

endmodule

// File: rtl/bcd_counter_multi.sv
// rtl/bcd_counter_multi.sv - N-decade up/down BCD counter with load, saturate and cascade carry
module bcd_counter_multi
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SATURATE = 0
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic                    up,
   input  logic                    load,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   output logic [BCD_W*DIGITS-1:0] dout,
   output logic                    tc,
   output logic                    wrapped,
   output logic                    load_err
);

   logic [DIGITS:0] w_carry;
   logic            w_hold;
   logic            w_load_bad;
   logic            r_wrapped;
   logic            r_load_err;

   // Carry chain enters at digit 0 with the count enable; its far end is the range-end detect
   assign w_carry[0] = en;
   assign tc         = w_carry[DIGITS];

   // In saturate mode the whole vector freezes when the next step would cross a range end
   assign w_hold = (SATURATE != 0) ? w_carry[DIGITS] : 1'b0;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         bcd_digit u_digit (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .ld_digit (load_val[k*BCD_W +: BCD_W]),
            .ci       (w_carry[k]),
            .up       (up),
            .hold_en  (w_hold),
            .q        (dout[k*BCD_W +: BCD_W]),
            .co       (w_carry[k+1])
         );
      end
   endgenerate

   // Flag any non-decimal nibble in the load word
   always_comb begin
      w_load_bad = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (!is_bcd(load_val[k*BCD_W +: BCD_W])) begin
            w_load_bad = 1'b1;
         end
      end
   end

   // One-cycle status pulses: wrap after a non-saturating range crossing, error after a bad load
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wrapped  <= 1'b0;
         r_load_err <= 1'b0;
      end else if (load) begin
         r_wrapped  <= 1'b0;
         r_load_err <= w_load_bad;
      end else begin
         r_wrapped  <= w_carry[DIGITS] & (SATURATE == 0);
         r_load_err <= 1'b0;
      end
   end

   assign wrapped  = r_wrapped;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_counter_multi.sv
// tb/tb_bcd_counter_multi.sv - self-checking bench for bcd_counter_multi against an integer model
module tb_bcd_counter_multi;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, en, up, load;
   logic [15:0] load_val;
   logic [15:0] dout0, dout1;
   logic        tc0, tc1, wr0, wr1, le0, le1;

   logic        c_reset, c_en, c_up, c_load;
   logic [15:0] c_lv;
   logic [7:0]  lo_dout, hi_dout;
   logic        lo_tc, hi_tc, lo_wr, hi_wr, lo_le, hi_le;

   int checks   = 0;
   int failures = 0;

   int mv  [3];
   bit mwr [3];
   bit mle [3];

   bcd_counter_multi #(.DIGITS(4), .SATURATE(0)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .dout(dout0), .tc(tc0), .wrapped(wr0), .load_err(le0));

   bcd_counter_multi #(.DIGITS(4), .SATURATE(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
      .dout(dout1), .tc(tc1), .wrapped(wr1), .load_err(le1));

   bcd_counter_multi #(.DIGITS(2), .SATURATE(0)) u_lo (
      .clk(clk), .reset(c_reset), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv[7:0]),
      .dout(lo_dout), .tc(lo_tc), .wrapped(lo_wr), .load_err(lo_le));

   bcd_counter_multi #(.DIGITS(2), .SATURATE(0)) u_hi (
      .clk(clk), .reset(c_reset), .en(lo_tc), .up(c_up), .load(c_load), .load_val(c_lv[15:8]),
      .dout(hi_dout), .tc(hi_tc), .wrapped(hi_wr), .load_err(hi_le));

   function automatic logic [31:0] int2bcd(input int v);
      logic [31:0] r;
      int          t;
      r = '0;
      t = v;
      for (int k = 0; k < 4; k++) begin
         r[4*k +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit exp_tc(input int i, input bit e, input bit u);
      return e && ((u && mv[i] == 9999) || (!u && mv[i] == 0));
   endfunction

   // Integer reference: 4-digit value 0..9999 with wrap or saturate at the ends
   function automatic void model_step(input int i, input bit sat, input bit r, input bit l,
                                      input bit e, input bit u, input logic [15:0] lv);
      int v, pw, d;
      bit err;
      if (r) begin
         mv[i] = 0; mwr[i] = 0; mle[i] = 0;
      end else if (l) begin
         v = 0; pw = 1; err = 0;
         for (int k = 0; k < 4; k++) begin
            d = int'(lv[4*k +: 4]);
            if (d > 9) begin
               err = 1;
               d = 0;
            end
            v = v + d * pw;
            pw = pw * 10;
         end
         mv[i] = v; mwr[i] = 0; mle[i] = err;
      end else if (e) begin
         mle[i] = 0;
         mwr[i] = 0;
         if (u) begin
            if (mv[i] == 9999) begin
               if (!sat) begin mv[i] = 0; mwr[i] = 1; end
            end else begin
               mv[i] = mv[i] + 1;
            end
         end else begin
            if (mv[i] == 0) begin
               if (!sat) begin mv[i] = 9999; mwr[i] = 1; end
            end else begin
               mv[i] = mv[i] - 1;
            end
         end
      end else begin
         mwr[i] = 0; mle[i] = 0;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one cycle on the two 4-digit instances, check tc before the edge and state after
   task automatic step(input bit r, input bit l, input bit e, input bit u, input logic [15:0] lv);
      reset = r; load = l; en = e; up = u; load_val = lv;
      #1;
      chk("tc_wrap", {31'b0, tc0}, {31'b0, exp_tc(0, e, u)});
      chk("tc_sat",  {31'b0, tc1}, {31'b0, exp_tc(1, e, u)});
      @(posedge clk);
      #1;
      model_step(0, 1'b0, r, l, e, u, lv);
      model_step(1, 1'b1, r, l, e, u, lv);
      chk("dout_wrap",  {16'b0, dout0}, int2bcd(mv[0]));
      chk("wrapped_wrap", {31'b0, wr0}, {31'b0, mwr[0]});
      chk("loaderr_wrap", {31'b0, le0}, {31'b0, mle[0]});
      chk("dout_sat",   {16'b0, dout1}, int2bcd(mv[1]));
      chk("wrapped_sat", {31'b0, wr1}, {31'b0, mwr[1]});
      chk("loaderr_sat", {31'b0, le1}, {31'b0, mle[1]});
      @(negedge clk);
   endtask

   // Drive one cycle on the chained 2+2 digit pair, treated as one 4-digit counter
   task automatic cstep(input bit r, input bit l, input bit e, input bit u, input logic [15:0] lv);
      c_reset = r; c_load = l; c_en = e; c_up = u; c_lv = lv;
      #1;
      chk("tc_chain", {31'b0, hi_tc}, {31'b0, exp_tc(2, e, u)});
      @(posedge clk);
      #1;
      model_step(2, 1'b0, r, l, e, u, lv);
      chk("dout_chain", {16'b0, hi_dout, lo_dout}, int2bcd(mv[2]));
      chk("wrapped_chain", {31'b0, hi_wr}, {31'b0, mwr[2]});
      chk("loaderr_chain", {31'b0, lo_le | hi_le}, {31'b0, mle[2]});
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_lv();
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
         0: return 16'h9999;
         1: return 16'h0000;
         2: return 16'(int2bcd(int'($urandom_range(0, 9999))));
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
      c_reset = 1'b1; c_load = 1'b0; c_en = 1'b0; c_up = 1'b1; c_lv = '0;
      for (int i = 0; i < 3; i++) begin mv[i] = 0; mwr[i] = 0; mle[i] = 0; end
      repeat (2) @(posedge clk);
      @(negedge clk);

      step(1, 0, 1, 1, 16'h0000);
      for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 16'h0000);

      step(0, 1, 0, 1, 16'h9998);
      for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'h0000);

      step(0, 1, 0, 0, 16'h1000);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'h0000);
      step(0, 1, 0, 0, 16'h0000);
      for (int i = 0; i < 2; i++) step(0, 0, 1, 0, 16'h0000);

      step(0, 1, 0, 1, 16'h12F4);
      step(0, 0, 0, 1, 16'h0000);
      step(0, 1, 1, 1, 16'h4321);
      step(0, 0, 1, 0, 16'h0000);
      step(0, 0, 1, 1, 16'h0000);

      step(0, 1, 0, 1, 16'h5555);
      step(1, 1, 1, 1, 16'h7777);
      step(0, 0, 0, 1, 16'h0000);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, 1'($urandom), rand_lv());
      end

      reset = 1'b0; load = 1'b0; en = 1'b0;
      cstep(1, 0, 0, 1, 16'h0000);
      cstep(0, 1, 0, 1, 16'h0099);
      for (int i = 0; i < 3; i++) cstep(0, 0, 1, 1, 16'h0000);
      cstep(0, 1, 0, 0, 16'h0101);
      for (int i = 0; i < 3; i++) cstep(0, 0, 1, 0, 16'h0000);
      cstep(0, 1, 0, 0, 16'h0000);
      cstep(0, 0, 1, 0, 16'h0000);
      cstep(0, 0, 1, 1, 16'h0000);
      for (int i = 0; i < 300; i++) begin
         cstep($urandom_range(0, 29) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 3) != 0, 1'($urandom), rand_lv());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_counter_multi.md
Name: bcd_counter_multi

Overview:
- Parametrised multi-digit BCD counter, the successor to our single-decade counter. Adds an N-digit width, up/down counting, synchronous parallel load, count enable and an optional saturate mode.
- Drives display/timer paths in the lab designs.
- Exposes a cascade carry so several instances can be chained into wider counters.

Parameters:
- DIGITS, 4, number of BCD decades (1..8); count range 0 .. 10^DIGITS-1.
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  reset, synchronous, active-high.
- en  input  1  count enable; for cascading, connect to the previous stage's tc.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load strobe.
- load_val  input  4*DIGITS  BCD value to load; digit 0 is bits [3:0].
- dout  output  4*DIGITS  registered BCD count.
- tc  output  1  terminal count, combinational: en & up & (dout == all-9s), or en & ~up & (dout == all-0s).
- wrapped  output  1  registered; high for one cycle after a wrap event.
- load_err  output  1  registered; high for one cycle after a load that contained an invalid digit.

Behaviour:
- Reset values: dout = 0, wrapped = 0, load_err = 0. Reset takes priority over every other input.
- Priority order each rising clk edge: reset > load > en > hold.
- Load:
  - Each digit of load_val that is 0..9 is loaded as given.
  - Any digit 10..15 is loaded as 0, and load_err = 1 on the following cycle.
  - A load ignores en and up; wrapped = 0 on a load cycle.
- Count, up (en=1, up=1): digit k increments when all lower digits equal 9. A digit at 9 that receives a carry goes to 0 and propagates the carry.
- Count, down (en=1, up=0): digit k decrements when all lower digits equal 0. A digit at 0 that receives a borrow goes to 9.
- Range end, up: dout = all 9s with en=1, up=1.
  - SATURATE=0: dout → 0, wrapped = 1 next cycle.
  - SATURATE=1: dout holds, wrapped stays 0.
- Range end, down: dout = 0 with en=1, up=0.
  - SATURATE=0: dout → all 9s, wrapped = 1.
  - SATURATE=1: dout holds.
- tc:
  - Asserted regardless of SATURATE.
  - Purely combinational, with zero added latency, so a downstream instance with en = tc advances on the same edge.
  - Must not depend on load or reset.
- en=0: dout holds; wrapped and load_err return to 0.
- Latency: one clock from input sample to dout update.
- Direction may change on any cycle. The new direction applies from that edge, with no extra state.
- Reset mid-count clears everything on that edge, including a pending load in the same cycle.
- dout never holds a non-BCD digit, from any input sequence.
- Counting is decimal per digit, not binary on the whole vector. There are no binary adders wider than 4 bits.

Decomposition:
- Shared package (bcd_pkg): BCD_W = 4, BCD_MAX = 4'd9, BCD_MIN = 4'd0, and a function is_bcd(digit).
- Sub-module bcd_digit, instantiated DIGITS times in a generate loop:
  - Inputs: clk, reset, load, ld_digit, ci (carry/borrow in), up, hold_en.
  - Outputs: q, co.
  - co = ci & (up ? q==9 : q==0).
  - The top-level forms hold_en from SATURATE and the global range-end detect.
- Top level holds the carry chain, the tc logic, and the wrapped/load_err registers.

Test Plan (DIGITS=4 unless stated):
1. Reset, then en=1, up=1 for 12 cycles → dout steps 0000, 0001 … 0009, 0010, 0011, 0012; tc = 0 throughout.
2. Load 0x9998, then count up 3 cycles → dout 9998, 9999 (tc=1), 0000 with wrapped=1 one cycle after the wrap. Repeat with SATURATE=1 → dout stays 9999, wrapped=0, tc stays 1.
3. Load 0x1000, up=0, 2 cycles → 0999, then 0998. Load 0x0000, up=0 → 9999 with wrapped=1 (SATURATE=0), or stays 0000 (SATURATE=1).
4. Load 0x12F4 → dout 1204, load_err=1 for exactly one cycle. Load together with en=1, up=1 in the same cycle → load wins, dout = load_val.
5. Assert reset in the same cycle as load=1 and en=1 while dout=5555 → dout=0000, wrapped=0, load_err=0.
6. Two DIGITS=2 instances chained (hi.en = lo.tc):
   - From 0099 with up, one step → 0100.
   - Toggle up=0 mid-run → counts down, and the 0100 → 0099 borrow crosses instances on the same edge.
